// File: rtl/dmem_port_ctrl_if.sv
// Shared rv32i pipeline packet types and the MEM-stage data-memory bus.
// Latency: n/a (type and signal bundle only).
// Backpressure: bus requests are held until the one-cycle dmem_resp pulse.
package rv32i_types;
    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       trap;
    } inst_t;

    typedef struct packed {
        logic mem;
        logic data_mem_read;
        logic data_mem_write;
        logic reg_write;
    } ctrl_t;

    typedef struct packed {
        rv32i_word  alu_out;
        rv32i_word  rs2_out;
        rv32i_word  mem_addr;
        logic [3:0] rmask;
        logic [3:0] wmask;
        rv32i_word  mem_wdata;
        rv32i_word  mem_rdata;
        rv32i_word  mdrreg_out;
    } data_t;

    typedef struct packed {
        inst_t inst;
        ctrl_t ctrl;
        data_t data;
    } rv32i_packet_t;
endpackage

interface dmem_port_ctrl_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/dmem_port_ctrl.sv
// MEM-stage data-memory port controller: issues cache requests and fills MEM fields of the packet.
// Latency: aligned access emits 2+k cycles after acceptance (k = resp delay); others pass through same cycle.
// Backpressure: mem_stall holds IF..MEM until the response is captured; requests held until dmem_resp.
module dmem_port_ctrl
    import rv32i_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  rv32i_packet_t        in_pkt,
    output logic                 mem_stall,
    output logic                 out_valid,
    output rv32i_packet_t        out_pkt,
    dmem_port_ctrl_if.master     dmem
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    rv32i_word  addr_q, addr_d;
    logic [3:0] be_q, be_d;
    rv32i_word  wdata_q, wdata_d;
    rv32i_word  mdr_q, mdr_d;
    rv32i_word  rdata_q, rdata_d;

    logic [1:0]    off;
    logic [2:0]    f3;
    logic [3:0]    mask;
    logic          misaligned;
    logic          mem_op;
    logic          aligned_op;
    rv32i_word     shifted;
    rv32i_word     load_val;
    rv32i_packet_t pkt;

    // Decode the access: lane mask, alignment, and aligned/extended load data.
    always_comb begin
        off        = in_pkt.data.alu_out[1:0];
        f3         = in_pkt.inst.funct3;
        case (f3[1:0])
            2'b00:   mask = 4'b0001 << off;
            2'b01:   mask = 4'b0011 << off;
            default: mask = 4'b1111;
        endcase
        // funct3[1] set means a word access (sw/lw); halves only fault at offset 3.
        misaligned = ((f3[1:0] == 2'b01) && (off == 2'b11)) || (f3[1] && (off != 2'b00));
        mem_op     = in_valid && in_pkt.ctrl.mem &&
                     (in_pkt.ctrl.data_mem_read || in_pkt.ctrl.data_mem_write);
        aligned_op = mem_op && !misaligned;
        shifted    = dmem.dmem_rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'h0, shifted[7:0]};
            3'b101:  load_val = {16'h0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Request FSM: register the request on acceptance, hold it until resp, then emit.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        mdr_d   = mdr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (aligned_op) begin
                    state_d = REQ;
                    rd_d    = in_pkt.ctrl.data_mem_read;
                    wr_d    = in_pkt.ctrl.data_mem_write;
                    addr_d  = {in_pkt.data.alu_out[31:2], 2'b00};
                    be_d    = mask;
                    wdata_d = in_pkt.data.rs2_out << {off, 3'b000};
                    mdr_d   = '0;
                    rdata_d = '0;
                end
            end
            REQ: begin
                if (dmem.dmem_resp) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (rd_q) begin
                        mdr_d   = load_val;
                        rdata_d = dmem.dmem_rdata;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
            rdata_q <= rdata_d;
        end
    end

    // Pipeline-facing outputs; everything is forced low while reset is held.
    always_comb begin
        pkt                 = in_pkt;
        pkt.data.mem_addr   = '0;
        pkt.data.rmask      = '0;
        pkt.data.wmask      = '0;
        pkt.data.mem_wdata  = '0;
        pkt.data.mem_rdata  = '0;
        pkt.data.mdrreg_out = '0;
        if (mem_op) begin
            if (misaligned) begin
                // Faulting address is reported unaligned so the trap handler sees it.
                pkt.inst.trap     = 1'b1;
                pkt.data.mem_addr = in_pkt.data.alu_out;
            end else begin
                pkt.data.mem_addr   = addr_q;
                pkt.data.rmask      = in_pkt.ctrl.data_mem_read  ? be_q    : 4'h0;
                pkt.data.wmask      = in_pkt.ctrl.data_mem_write ? be_q    : 4'h0;
                pkt.data.mem_wdata  = in_pkt.ctrl.data_mem_write ? wdata_q : 32'h0;
                pkt.data.mem_rdata  = rdata_q;
                pkt.data.mdrreg_out = mdr_q;
            end
        end
        out_pkt   = rst ? pkt : '0;
        mem_stall = rst && aligned_op && (state_q != DONE);
        out_valid = rst && (aligned_op ? (state_q == DONE) : in_valid);
    end

    // Bus-facing outputs come straight from the request registers.
    always_comb begin
        dmem.dmem_read        = rst && rd_q;
        dmem.dmem_write       = rst && wr_q;
        dmem.dmem_address     = rst ? addr_q  : 32'h0;
        dmem.dmem_byte_enable = rst ? be_q    : 4'h0;
        dmem.dmem_wdata       = rst ? wdata_q : 32'h0;
    end

endmodule
